bullet_overlay_draw: RTL and testbench
======================================

# bullet_overlay_draw

Parametrised VGA pipeline stage that overlays up to N bullets and their impact explosions onto the incoming pixel stream. Each channel runs its own IDLE/FLY/EXPLODE/SPENT state machine driven by bullet position and a hit pulse. All timing signals pass through with one cycle of latency. It sits in the draw chain after the tank/background stages and before the VGA output register.

## Interface
- N_BULLETS, 2: number of independent bullet channels (1..8).
- BULLET_SIZE, 4: side length in pixels of the in-flight square.
- EXPLODE_SIZE, 8: side length in pixels of the explosion square (even, ≥ BULLET_SIZE).
- EXPLODE_FRAMES, 8: explosion duration in frames (1..255).
- BULLET_RGB, 12'h000: in-flight colour.
- EXPLODE_RGB, 12'hF80: explosion colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- bullet_x  in  10*N_BULLETS  per-channel x position; channel i is bits [10i+9:10i].
- bullet_y  in  10*N_BULLETS  per-channel y position, same packing.
- bullet_hit  in  N_BULLETS  one-cycle impact pulse per channel.
- hblnk, vblnk, hsync, vsync  in  1 each  video timing.
- hcount  in  11  horizontal pixel counter.
- vcount  in  10  vertical pixel counter.
- rgb  in  12  upstream pixel.
- hblnk_out, vblnk_out, hsync_out, vsync_out  out  1 each  delayed timing.
- hcount_out  out  11  delayed hcount.
- vcount_out  out  10  delayed vcount.
- rgb_out  out  12  composed pixel.
- bullet_active_out  out  N_BULLETS  bit i high while channel i is in FLY or EXPLODE.

## Operation
- Position (0,0) means "no bullet".
- Per-channel states:
  - IDLE: if pos ≠ (0,0), go to FLY.
  - FLY: latch pos into ex/ey every cycle.
    - bullet_hit → EXPLODE; clear the frame counter.
    - Else pos = (0,0) → IDLE (bullet left the screen).
  - EXPLODE: count frame ticks. When the count reaches EXPLODE_FRAMES, go to SPENT.
  - SPENT: stay until pos = (0,0), then go to IDLE. This prevents a stale position from re-launching the bullet.
- Simultaneous bullet_hit and pos = (0,0) in FLY: the hit wins. The explosion uses the last latched nonzero position, i.e. the latch is not updated with (0,0).
- bullet_hit in IDLE, EXPLODE or SPENT is ignored.
- Frame tick is the rising edge of vblnk, detected against a registered copy of vblnk.
- Draw regions, all compares 11-bit unsigned:
  - FLY: x ≤ hcount < x+BULLET_SIZE and y ≤ vcount < y+BULLET_SIZE.
  - EXPLODE: the square of side EXPLODE_SIZE with left/top edge at ex−EXPLODE_SIZE/2 and ey−EXPLODE_SIZE/2. Each edge clamps to 0 on underflow; right/bottom edge stays at ex+EXPLODE_SIZE/2 and ey+EXPLODE_SIZE/2, exclusive.
- Pixel priority: lowest channel index wins among channels covering the pixel. A covering channel outputs its state colour; no covering channel passes rgb through.
- During hblnk or vblnk, rgb passes through unmodified.
- Draw decision uses the current registered state and the current hcount/vcount/positions.

## Timing
- Latency is exactly 1 clk for every output relative to its inputs; rgb_out is aligned with hcount_out/vcount_out.
- State transitions take effect on the clk edge after the triggering input. A bullet becomes visible starting with the pixel sampled in the cycle after FLY is entered.
- EXPLODE lasts EXPLODE_FRAMES vblnk rising edges after entry. A tick coinciding with the entry cycle is not counted.
- Reset values:
  - All outputs 0, including rgb_out and bullet_active_out.
  - All channels IDLE; counters, latches and the vblnk delay register 0.
- Reset mid-explosion aborts it immediately. The first post-reset cycle outputs a pass-through pixel.

## Structure
- Shared package bullet_pkg holds:
  - the state enum (IDLE=2'd0, FLY=2'd1, EXPLODE=2'd2, SPENT=2'd3);
  - position width constants (X_W=10, CNT_W=11).
- Sub-module bullet_channel_fsm, instantiated N_BULLETS times. It contains:
  - inputs: pos, hit, frame tick, hcount, vcount;
  - state register, position latch, frame counter;
  - outputs: draw_fly, draw_explode, active.
- Top level holds the timing delay registers, the vblnk edge detector, the priority mux and the output register.

## Test plan
- Launch: channel 0 pos (100,50) from (0,0) → bullet_active_out[0]=1 next cycle; rgb_out=12'h000 for hcount 100..103, vcount 50..53; neighbours pass rgb.
- Exit: in FLY, pos → (0,0) with no hit → IDLE, active=0, no pixels drawn next frame.
- Hit and explosion: hit at pos (100,50) → 12'hF80 square over x 96..103, y 46..53 for exactly 8 frames, then SPENT (active=0). pos held (100,50) → stays SPENT; pos (0,0) → IDLE.
- Simultaneous events: hit and pos=(0,0) in the same cycle at latched (20,30) → explosion at (20,30). Clamp case: hit at (2,2) → explosion x 0..5, y 0..5.
- Priority and blanking: channels 0 and 1 overlap at (200,200), 0 flying, 1 exploding → overlap pixels 12'h000. With hblnk=1 over the region → rgb_out equals rgb.
- Reset: rst during EXPLODE → all outputs 0 the next cycle, all states IDLE; after release, pos (0,0) → no drawing.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types and widths for the bullet overlay stage.
package bullet_pkg;

  localparam int unsigned X_W   = 10;
  localparam int unsigned CNT_W = 11;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFly     = 2'd1,
    StExplode = 2'd2,
    StSpent   = 2'd3
  } bullet_state_e;

endpackage

// File: rtl/bullet_channel_fsm.sv
// One bullet channel: IDLE/FLY/EXPLODE/SPENT state machine plus its draw-region decode.
module bullet_channel_fsm
  import bullet_pkg::*;
#(
  parameter int unsigned BULLET_SIZE    = 4,
  parameter int unsigned EXPLODE_SIZE   = 8,
  parameter int unsigned EXPLODE_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   pos_x,
  input  logic [X_W-1:0]   pos_y,
  input  logic             hit,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] hcount,
  input  logic [X_W-1:0]   vcount,
  output logic             draw_fly,
  output logic             draw_explode,
  output logic             active
);

  localparam logic [CNT_W-1:0] BSize = CNT_W'(BULLET_SIZE);
  localparam logic [CNT_W-1:0] Half  = CNT_W'(EXPLODE_SIZE / 2);
  localparam logic [7:0]       NFrm  = 8'(EXPLODE_FRAMES);

  bullet_state_e  state_q, state_d;
  logic [X_W-1:0] ex_q, ex_d, ey_q, ey_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           pos_zero;

  assign pos_zero = (pos_x == '0) && (pos_y == '0);

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!pos_zero) begin
          state_d = StFly;
          ex_d    = pos_x;
          ey_d    = pos_y;
        end
      end
      StFly: begin
        // Never latch (0,0): a hit coinciding with exit explodes at the last real position.
        if (!pos_zero) begin
          ex_d = pos_x;
          ey_d = pos_y;
        end
        if (hit) begin
          state_d = StExplode;
          cnt_d   = '0;
        end else if (pos_zero) begin
          state_d = StIdle;
        end
      end
      StExplode: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == NFrm) state_d = StSpent;
        end
      end
      StSpent: begin
        if (pos_zero) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ex_q    <= '0;
      ey_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [CNT_W-1:0] px, py, hc, vc, exw, eyw, el, et, er, eb;

  always_comb begin
    px  = CNT_W'(pos_x);
    py  = CNT_W'(pos_y);
    hc  = hcount;
    vc  = CNT_W'(vcount);
    exw = CNT_W'(ex_q);
    eyw = CNT_W'(ey_q);
    el  = (exw >= Half) ? exw - Half : '0;
    et  = (eyw >= Half) ? eyw - Half : '0;
    er  = exw + Half;
    eb  = eyw + Half;
    draw_fly = (state_q == StFly) && (hc >= px) && (hc < px + BSize)
               && (vc >= py) && (vc < py + BSize);
    draw_explode = (state_q == StExplode) && (hc >= el) && (hc < er)
                   && (vc >= et) && (vc < eb);
    active = (state_q == StFly) || (state_q == StExplode);
  end

endmodule

// File: rtl/bullet_overlay_draw.sv
// Draw-chain stage overlaying N bullet channels onto the pixel stream with one cycle of latency.
module bullet_overlay_draw
  import bullet_pkg::*;
#(
  parameter int unsigned N_BULLETS      = 2,
  parameter int unsigned BULLET_SIZE    = 4,
  parameter int unsigned EXPLODE_SIZE   = 8,
  parameter int unsigned EXPLODE_FRAMES = 8,
  parameter logic [11:0] BULLET_RGB     = 12'h000,
  parameter logic [11:0] EXPLODE_RGB    = 12'hF80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10*N_BULLETS-1:0]  bullet_x,
  input  logic [10*N_BULLETS-1:0]  bullet_y,
  input  logic [N_BULLETS-1:0]     bullet_hit,
  input  logic                     hblnk,
  input  logic                     vblnk,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic [11:0]              rgb,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic [11:0]              rgb_out,
  output logic [N_BULLETS-1:0]     bullet_active_out
);

  logic                 vblnk_q;
  logic                 frame_tick;
  logic [N_BULLETS-1:0] draw_fly, draw_explode, active;
  logic [11:0]          pix;

  assign frame_tick = vblnk & ~vblnk_q;

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_ch
    bullet_channel_fsm #(
      .BULLET_SIZE    (BULLET_SIZE),
      .EXPLODE_SIZE   (EXPLODE_SIZE),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .pos_x        (bullet_x[10*i +: 10]),
      .pos_y        (bullet_y[10*i +: 10]),
      .hit          (bullet_hit[i]),
      .frame_tick   (frame_tick),
      .hcount       (hcount),
      .vcount       (vcount),
      .draw_fly     (draw_fly[i]),
      .draw_explode (draw_explode[i]),
      .active       (active[i])
    );
  end

  // Scan from the highest channel down so the lowest covering index has the last word.
  always_comb begin
    pix = rgb;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (draw_fly[i])          pix = BULLET_RGB;
      else if (draw_explode[i]) pix = EXPLODE_RGB;
    end
    if (hblnk || vblnk) pix = rgb;
  end

  assign bullet_active_out = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q    <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      rgb_out    <= '0;
    end else begin
      vblnk_q    <= vblnk;
      hblnk_out  <= hblnk;
      vblnk_out  <= vblnk;
      hsync_out  <= hsync;
      vsync_out  <= vsync;
      hcount_out <= hcount;
      vcount_out <= vcount;
      rgb_out    <= pix;
    end
  end

endmodule

// File: tb/tb_bullet_overlay_draw.sv
// Directed bench for bullet_overlay_draw with hand-computed expected pixels and states.
module tb_bullet_overlay_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] bullet_x, bullet_y;
  logic [1:0]  bullet_hit;
  logic        hblnk, vblnk, hsync, vsync;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] rgb;
  logic        hblnk_out, vblnk_out, hsync_out, vsync_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [11:0] rgb_out;
  logic [1:0]  bullet_active_out;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] Bg  = 12'h123;
  localparam logic [11:0] Blt = 12'h000;
  localparam logic [11:0] Exp = 12'hF80;

  always #5 clk = ~clk;

  bullet_overlay_draw dut (
    .clk               (clk),
    .rst               (rst),
    .bullet_x          (bullet_x),
    .bullet_y          (bullet_y),
    .bullet_hit        (bullet_hit),
    .hblnk             (hblnk),
    .vblnk             (vblnk),
    .hsync             (hsync),
    .vsync             (vsync),
    .hcount            (hcount),
    .vcount            (vcount),
    .rgb               (rgb),
    .hblnk_out         (hblnk_out),
    .vblnk_out         (vblnk_out),
    .hsync_out         (hsync_out),
    .vsync_out         (vsync_out),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out),
    .rgb_out           (rgb_out),
    .bullet_active_out (bullet_active_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int hc, input int vc);
    hcount = 11'(hc);
    vcount = 10'(vc);
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int ch, input int x, input int y);
    bullet_x[10*ch +: 10] = 10'(x);
    bullet_y[10*ch +: 10] = 10'(y);
  endtask

  task automatic pix(input string tag, input int hc, input int vc, input logic [11:0] exp);
    step(hc, vc);
    check(tag, 32'(rgb_out), 32'(exp));
  endtask

  task automatic frame_pulse();
    vblnk = 1'b1;
    step(0, 0);
    vblnk = 1'b0;
    step(0, 0);
  endtask

  task automatic hit(input int ch);
    bullet_hit[ch] = 1'b1;
    step(0, 0);
    bullet_hit[ch] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bullet_x = '0; bullet_y = '0; bullet_hit = '0;
    hblnk = 0; vblnk = 0; hsync = 0; vsync = 0; rgb = Bg;
    step(5, 7);
    step(5, 7);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_hcount", 32'(hcount_out), 32'h0);
    check("rst_active", 32'(bullet_active_out), 32'h0);
    rst = 1'b0;

    hsync = 1; vsync = 1;
    step(100, 50);
    check("pass_rgb", 32'(rgb_out), 32'(Bg));
    check("pass_hcount", 32'(hcount_out), 32'd100);
    check("pass_vcount", 32'(vcount_out), 32'd50);
    check("pass_hsync", 32'(hsync_out), 32'd1);
    check("pass_vsync", 32'(vsync_out), 32'd1);
    hsync = 0; vsync = 0;

    // Launch: the entry cycle itself still passes through.
    set_pos(0, 100, 50);
    pix("launch_entry", 100, 50, Bg);
    check("launch_active", 32'(bullet_active_out), 32'd1);
    pix("fly_tl", 100, 50, Blt);
    pix("fly_br", 103, 53, Blt);
    pix("fly_right", 104, 50, Bg);
    pix("fly_left", 99, 50, Bg);
    pix("fly_below", 100, 54, Bg);
    pix("fly_above", 100, 49, Bg);

    // Exit without hit.
    set_pos(0, 0, 0);
    step(0, 0);
    check("exit_active", 32'(bullet_active_out), 32'd0);
    pix("exit_nodraw", 0, 0, Bg);
    pix("exit_nodraw2", 100, 50, Bg);

    // Hit together with a vblnk rising edge: that tick must not count.
    set_pos(0, 100, 50);
    step(0, 0);
    bullet_hit[0] = 1'b1; vblnk = 1'b1;
    step(0, 0);
    bullet_hit[0] = 1'b0; vblnk = 1'b0;
    step(0, 0);
    check("exp_active", 32'(bullet_active_out), 32'd1);
    pix("exp_tl", 96, 46, Exp);
    pix("exp_br", 103, 53, Exp);
    pix("exp_right", 104, 50, Bg);
    pix("exp_left", 95, 50, Bg);
    pix("exp_above", 100, 45, Bg);
    for (int i = 0; i < 7; i++) frame_pulse();
    check("exp_7frames", 32'(bullet_active_out), 32'd1);
    pix("exp_7frames_pix", 96, 46, Exp);
    frame_pulse();
    check("spent_active", 32'(bullet_active_out), 32'd0);
    pix("spent_nodraw", 100, 50, Bg);
    step(0, 0);
    step(0, 0);
    check("spent_hold", 32'(bullet_active_out), 32'd0);
    set_pos(0, 0, 0);
    step(0, 0);
    set_pos(0, 100, 50);
    step(0, 0);
    check("idle_relaunch", 32'(bullet_active_out), 32'd1);
    set_pos(0, 0, 0);
    step(0, 0);
    check("relaunch_exit", 32'(bullet_active_out), 32'd0);

    // Hit coinciding with exit explodes at the last latched position.
    set_pos(0, 20, 30);
    step(0, 0);
    step(0, 0);
    set_pos(0, 0, 0);
    hit(0);
    check("simul_active", 32'(bullet_active_out), 32'd1);
    pix("simul_tl", 16, 26, Exp);
    pix("simul_br", 23, 33, Exp);
    pix("simul_out", 24, 30, Bg);
    for (int i = 0; i < 8; i++) frame_pulse();
    step(0, 0);
    check("simul_done", 32'(bullet_active_out), 32'd0);

    // Clamp at the screen origin.
    set_pos(0, 2, 2);
    step(0, 0);
    hit(0);
    set_pos(0, 0, 0);
    pix("clamp_origin", 0, 0, Exp);
    pix("clamp_br", 5, 5, Exp);
    pix("clamp_right", 6, 0, Bg);
    pix("clamp_below", 0, 6, Bg);
    for (int i = 0; i < 8; i++) frame_pulse();
    step(0, 0);
    check("clamp_done", 32'(bullet_active_out), 32'd0);

    // Priority: channel 1 exploding over 198..205, channel 0 flying over 200..203.
    set_pos(1, 202, 202);
    step(0, 0);
    hit(1);
    set_pos(0, 200, 200);
    step(0, 0);
    check("prio_active", 32'(bullet_active_out), 32'd3);
    pix("prio_overlap", 200, 200, Blt);
    pix("prio_ch1_only", 204, 204, Exp);
    pix("prio_ch1_edge", 198, 198, Exp);
    hblnk = 1'b1;
    pix("prio_hblnk", 200, 200, Bg);
    check("prio_hblnk_out", 32'(hblnk_out), 32'd1);
    hblnk = 1'b0;

    // Synchronous reset aborts the explosion.
    rst = 1'b1;
    step(200, 200);
    check("mid_rst_rgb", 32'(rgb_out), 32'h0);
    check("mid_rst_active", 32'(bullet_active_out), 32'd0);
    check("mid_rst_hcount", 32'(hcount_out), 32'd0);
    rst = 1'b0;
    bullet_x = '0; bullet_y = '0;
    pix("post_rst_pass", 200, 200, Bg);
    pix("post_rst_pass2", 204, 204, Bg);
    check("post_rst_active", 32'(bullet_active_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
